ristretto_trap_ctrl: RTL and testbench

RISTRETTO_TRAP_CTRL -- requirements
Module: ristretto_trap_ctrl

---
 rtl/ristretto_trap_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ristretto_trap_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ristretto_trap_ctrl.sv
// Trap control unit: accepts exceptions, MRET and interrupts, then runs
// flush -> CSR write -> PC redirect.
// Ports: clk_i/rst_i (sync active-high); exc_*, commit_pc_i, boundary_i,
//   mret_i, mie_i/mpie_i, *_int_i {pending,enable}, mtvec_i, mepc_i in;
//   tcu_csr_we_o, csr_mcause_o/csr_mtval_o/csr_mepc_o/csr_trap_state_o,
//   flush_o, busy_o, redir_valid_o/redir_ready_i, redir_pc_o.
// Option: RISTRETTO_TCU_VECTORED_EN enables vectored interrupt targets.
module ristretto_trap_ctrl #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 exc_valid_i,
  input  logic [3:0]           exc_cause_i,
  input  logic [DataWidth-1:0] exc_tval_i,
  input  logic [AddrWidth-1:0] commit_pc_i,
  input  logic                 boundary_i,
  input  logic                 mret_i,
  input  logic                 mie_i,
  input  logic                 mpie_i,
  input  logic [1:0]           ext_int_i,
  input  logic [1:0]           tim_int_i,
  input  logic [1:0]           soft_int_i,
  input  logic [AddrWidth-1:0] mtvec_i,
  input  logic [AddrWidth-1:0] mepc_i,
  output logic                 tcu_csr_we_o,
  output logic [DataWidth-1:0] csr_mcause_o,
  output logic [DataWidth-1:0] csr_mtval_o,
  output logic [AddrWidth-1:0] csr_mepc_o,
  output logic [2:0]           csr_trap_state_o,
  output logic                 flush_o,
  output logic                 busy_o,
  output logic                 redir_valid_o,
  input  logic                 redir_ready_i,
  output logic [AddrWidth-1:0] redir_pc_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_WRITE,
    S_REDIR
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic                 w_accept;
  logic                 w_is_mret;
  logic                 w_is_int;
  logic [DataWidth-1:0] w_cause;
  logic [DataWidth-1:0] w_tval;

  logic                 r_is_mret;
  logic                 r_is_int;
  logic [DataWidth-1:0] r_cause;
  logic [DataWidth-1:0] r_tval;
  logic [AddrWidth-1:0] r_pc;
  logic [AddrWidth-1:0] r_mepc;

  logic                 r_flush;
  logic                 r_we;
  logic                 r_redir_valid;
  logic [DataWidth-1:0] r_csr_mcause;
  logic [DataWidth-1:0] r_csr_mtval;
  logic [AddrWidth-1:0] r_csr_mepc;
  logic [2:0]           r_csr_state;
  logic [AddrWidth-1:0] r_redir_pc;

  logic                 w_ext;
  logic                 w_tim;
  logic                 w_soft;
  logic                 w_int_req;
  logic [AddrWidth-1:0] w_base;
  logic [AddrWidth-1:0] w_trap_pc;
  logic [AddrWidth-1:0] w_redir_pc;

  assign w_ext     = &ext_int_i;
  assign w_tim     = &tim_int_i;
  assign w_soft    = &soft_int_i;
  assign w_int_req = boundary_i & mie_i
                   & (w_ext | w_tim | w_soft);

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_is_mret = 1'b0;
    w_is_int  = 1'b0;
    w_cause   = '0;
    w_tval    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (exc_valid_i) begin
          w_accept     = 1'b1;
          w_cause[3:0] = exc_cause_i;
          w_tval       = exc_tval_i;
        end else if (mret_i) begin
          w_accept  = 1'b1;
          w_is_mret = 1'b1;
        end else if (w_int_req) begin
          w_accept               = 1'b1;
          w_is_int               = 1'b1;
          w_cause[DataWidth-1]   = 1'b1;
          w_cause[3:0]           = w_ext  ? 4'hB :
                                   w_soft ? 4'h3 : 4'h7;
        end
        if (w_accept) w_state_d = S_FLUSH;
      end
      S_FLUSH: w_state_d = S_WRITE;
      S_WRITE: w_state_d = S_REDIR;
      S_REDIR: if (redir_ready_i) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  assign w_base = {mtvec_i[AddrWidth-1:2], 2'b00};

`ifdef RISTRETTO_TCU_VECTORED_EN
  // Vectored mode only offsets interrupts; exceptions use the base.
  assign w_trap_pc = (r_is_int && mtvec_i[1:0] == 2'b01)
                   ? w_base + AddrWidth'({r_cause[3:0], 2'b00})
                   : w_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^mtvec_i[1:0];
  assign w_trap_pc     = w_base;
`endif

  assign w_redir_pc = r_is_mret ? r_mepc : w_trap_pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_is_mret     <= 1'b0;
      r_is_int      <= 1'b0;
      r_cause       <= '0;
      r_tval        <= '0;
      r_pc          <= '0;
      r_mepc        <= '0;
      r_flush       <= 1'b0;
      r_we          <= 1'b0;
      r_redir_valid <= 1'b0;
      r_csr_mcause  <= '0;
      r_csr_mtval   <= '0;
      r_csr_mepc    <= '0;
      r_csr_state   <= '0;
      r_redir_pc    <= '0;
    end else begin
      r_state       <= w_state_d;
      // Strobes follow the next state so each lines up with its state.
      r_flush       <= (w_state_d == S_FLUSH);
      r_we          <= (w_state_d == S_WRITE);
      r_redir_valid <= (w_state_d == S_REDIR);
      if (w_accept) begin
        r_is_mret <= w_is_mret;
        r_is_int  <= w_is_int;
        r_cause   <= w_cause;
        r_tval    <= w_tval;
        r_pc      <= commit_pc_i;
        r_mepc    <= mepc_i;
      end
      if (r_state == S_FLUSH) begin
        r_csr_mcause <= r_cause;
        r_csr_mtval  <= r_tval;
        if (r_is_mret) begin
          r_csr_mepc  <= mepc_i;
          r_csr_state <= {mpie_i, 1'b1, 1'b0};
        end else begin
          r_csr_mepc  <= r_pc;
          r_csr_state <= {1'b0, mie_i, 1'b1};
        end
      end
      if (r_state == S_WRITE) r_redir_pc <= w_redir_pc;
    end
  end

  assign busy_o           = (r_state != S_IDLE);
  assign flush_o          = r_flush;
  assign tcu_csr_we_o     = r_we;
  assign redir_valid_o    = r_redir_valid;
  assign csr_mcause_o     = r_csr_mcause;
  assign csr_mtval_o      = r_csr_mtval;
  assign csr_mepc_o       = r_csr_mepc;
  assign csr_trap_state_o = r_csr_state;
  assign redir_pc_o       = r_redir_pc;

endmodule

// File: tb/tb_ristretto_trap_ctrl.sv
// Scoreboard bench for ristretto_trap_ctrl.
// Stimulus pushes expected flush/write/redirect items; a monitor checks them.
module tb_ristretto_trap_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;

`ifdef RISTRETTO_TCU_VECTORED_EN
  localparam logic [31:0] VEC_TIM_PC = 32'h0000_011C;
`else
  localparam logic [31:0] VEC_TIM_PC = 32'h0000_0100;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          exc_valid_i;
  logic [3:0]    exc_cause_i;
  logic [DW-1:0] exc_tval_i;
  logic [AW-1:0] commit_pc_i;
  logic          boundary_i;
  logic          mret_i;
  logic          mie_i;
  logic          mpie_i;
  logic [1:0]    ext_int_i;
  logic [1:0]    tim_int_i;
  logic [1:0]    soft_int_i;
  logic [AW-1:0] mtvec_i;
  logic [AW-1:0] mepc_i;
  logic          tcu_csr_we_o;
  logic [DW-1:0] csr_mcause_o;
  logic [DW-1:0] csr_mtval_o;
  logic [AW-1:0] csr_mepc_o;
  logic [2:0]    csr_trap_state_o;
  logic          flush_o;
  logic          busy_o;
  logic          redir_valid_o;
  logic          redir_ready_i;
  logic [AW-1:0] redir_pc_o;

  always #5 clk = ~clk;

  ristretto_trap_ctrl #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_tval_i(exc_tval_i), .commit_pc_i(commit_pc_i),
    .boundary_i(boundary_i), .mret_i(mret_i),
    .mie_i(mie_i), .mpie_i(mpie_i),
    .ext_int_i(ext_int_i), .tim_int_i(tim_int_i),
    .soft_int_i(soft_int_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .tcu_csr_we_o(tcu_csr_we_o), .csr_mcause_o(csr_mcause_o),
    .csr_mtval_o(csr_mtval_o), .csr_mepc_o(csr_mepc_o),
    .csr_trap_state_o(csr_trap_state_o), .flush_o(flush_o),
    .busy_o(busy_o), .redir_valid_o(redir_valid_o),
    .redir_ready_i(redir_ready_i), .redir_pc_o(redir_pc_o)
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mepc;
    logic [31:0] ts;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  task automatic push_evt(input int c, input logic [31:0] mc,
                          input logic [31:0] mt, input logic [31:0] mp,
                          input logic [31:0] ts, input logic [31:0] rpc,
                          input bit redir);
    q.push_back('{kind: 0, cyc: c + 1, mcause: 0, mtval: 0,
                  mepc: 0, ts: 0, rpc: 0});
    q.push_back('{kind: 1, cyc: c + 2, mcause: mc, mtval: mt,
                  mepc: mp, ts: ts, rpc: 0});
    if (redir)
      q.push_back('{kind: 2, cyc: c + 3, mcause: 0, mtval: 0,
                    mepc: 0, ts: 0, rpc: rpc});
  endtask

  exp_t        e;
  int          n_act;
  logic        prev_v = 1'b0;
  logic [31:0] hold_pc;

  task automatic no_item(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: output with empty scoreboard (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    n_act = int'(flush_o) + int'(tcu_csr_we_o) + int'(redir_valid_o);
    if (n_act > 0) chk("strobe_onehot", n_act, 1);
    if (flush_o) begin
      if (q.size() == 0) no_item("flush");
      else begin
        e = q.pop_front();
        chk("flush_kind", e.kind, 0);
        chk("flush_cycle", cyc, e.cyc);
      end
    end
    if (tcu_csr_we_o) begin
      if (q.size() == 0) no_item("we");
      else begin
        e = q.pop_front();
        chk("we_kind", e.kind, 1);
        chk("we_cycle", cyc, e.cyc);
        chk("mcause", csr_mcause_o, e.mcause);
        chk("mtval", csr_mtval_o, e.mtval);
        chk("mepc", csr_mepc_o, e.mepc);
        chk("trap_state", 32'(csr_trap_state_o), e.ts);
      end
    end
    if (redir_valid_o && !prev_v) begin
      if (q.size() == 0) no_item("redir");
      else begin
        e = q.pop_front();
        chk("redir_kind", e.kind, 2);
        chk("redir_cycle", cyc, e.cyc);
        chk("redir_pc", redir_pc_o, e.rpc);
      end
      hold_pc = redir_pc_o;
    end else if (redir_valid_o) begin
      chk("redir_pc_stable", redir_pc_o, hold_pc);
    end
    prev_v = redir_valid_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    exc_valid_i = 1'b0;
    mret_i      = 1'b0;
    ext_int_i   = 2'b00;
    tim_int_i   = 2'b00;
    soft_int_i  = 2'b00;
    boundary_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_o && k < 40) begin
      tick();
      k++;
    end
    chk("idle_timeout", 32'(busy_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    clr();
    rst_i         = 1'b1;
    exc_cause_i   = '0;
    exc_tval_i    = '0;
    commit_pc_i   = '0;
    mie_i         = 1'b1;
    mpie_i        = 1'b0;
    mtvec_i       = 32'h100;
    mepc_i        = '0;
    redir_ready_i = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_flush", 32'(flush_o), 0);
    chk("rst_we", 32'(tcu_csr_we_o), 0);
    chk("rst_valid", 32'(redir_valid_o), 0);
    chk("rst_redir_pc", redir_pc_o, 0);
    rst_i = 1'b0;

    // Synchronous exception.
    c = cyc;
    exc_valid_i = 1'b1; exc_cause_i = 4'd2;
    exc_tval_i = 32'h13; commit_pc_i = 32'h80;
    push_evt(c, 32'd2, 32'h13, 32'h80, 32'b011, 32'h100, 1'b1);
    tick();
    clr();
    wait_idle();

    // Exception beats MRET and interrupt; interrupt follows.
    c = cyc;
    exc_valid_i = 1'b1; exc_cause_i = 4'd5; exc_tval_i = 32'hAA;
    commit_pc_i = 32'h90; mret_i = 1'b1;
    ext_int_i = 2'b11; boundary_i = 1'b1;
    push_evt(c, 32'd5, 32'hAA, 32'h90, 32'b011, 32'h100, 1'b1);
    push_evt(c + 4, 32'h8000000B, 32'h0, 32'h94, 32'b011,
             32'h100, 1'b1);
    tick();
    exc_valid_i = 1'b0; mret_i = 1'b0; commit_pc_i = 32'h94;
    while (cyc < c + 5) tick();
    clr();
    wait_idle();

    // Soft beats timer.
    c = cyc;
    soft_int_i = 2'b11; tim_int_i = 2'b11;
    boundary_i = 1'b1; commit_pc_i = 32'hA0;
    push_evt(c, 32'h80000003, 32'h0, 32'hA0, 32'b011, 32'h100, 1'b1);
    tick();
    clr();
    wait_idle();

    // Masked by MIE, then no boundary.
    mie_i = 1'b0; soft_int_i = 2'b11; boundary_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mie_mask_busy", 32'(busy_o), 0);
    end
    mie_i = 1'b1; boundary_i = 1'b0;
    tick();
    chk("no_boundary_busy", 32'(busy_o), 0);
    clr();

    // MRET with back-pressured redirect.
    redir_ready_i = 1'b0;
    c = cyc;
    mret_i = 1'b1; mepc_i = 32'h244; mpie_i = 1'b1;
    push_evt(c, 32'h0, 32'h0, 32'h244, 32'b110, 32'h244, 1'b1);
    tick();
    clr();
    while (cyc < c + 6) begin
      tick();
      chk("mret_busy", 32'(busy_o), 1);
    end
    redir_ready_i = 1'b1;
    tick();
    chk("mret_done_busy", 32'(busy_o), 0);
    chk("mret_done_valid", 32'(redir_valid_o), 0);
    mpie_i = 1'b0;

    // Reset during WRITE.
    c = cyc;
    exc_valid_i = 1'b1; exc_cause_i = 4'd7;
    exc_tval_i = 32'h55; commit_pc_i = 32'hC0;
    push_evt(c, 32'd7, 32'h55, 32'hC0, 32'b011, 32'h0, 1'b0);
    tick();
    clr();
    tick();
    rst_i = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_flush", 32'(flush_o), 0);
    chk("midrst_we", 32'(tcu_csr_we_o), 0);
    chk("midrst_valid", 32'(redir_valid_o), 0);
    chk("midrst_mcause", csr_mcause_o, 0);
    chk("midrst_mtval", csr_mtval_o, 0);
    chk("midrst_mepc", csr_mepc_o, 0);
    chk("midrst_state", 32'(csr_trap_state_o), 0);
    chk("midrst_redir_pc", redir_pc_o, 0);
    rst_i = 1'b0;
    c = cyc;
    exc_valid_i = 1'b1; exc_cause_i = 4'd3;
    exc_tval_i = 32'h77; commit_pc_i = 32'hD0;
    push_evt(c, 32'd3, 32'h77, 32'hD0, 32'b011, 32'h100, 1'b1);
    tick();
    clr();
    wait_idle();

    // Vectored mode: timer interrupt, then an exception.
    mtvec_i = 32'h101;
    c = cyc;
    tim_int_i = 2'b11; boundary_i = 1'b1; commit_pc_i = 32'hE0;
    push_evt(c, 32'h80000007, 32'h0, 32'hE0, 32'b011,
             VEC_TIM_PC, 1'b1);
    tick();
    clr();
    wait_idle();
    c = cyc;
    exc_valid_i = 1'b1; exc_cause_i = 4'd4;
    exc_tval_i = 32'h0; commit_pc_i = 32'hF0;
    push_evt(c, 32'd4, 32'h0, 32'hF0, 32'b011, 32'h100, 1'b1);
    tick();
    clr();
    wait_idle();
    mtvec_i = 32'h100;

    repeat (3) tick();
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
